// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared k-NN accelerator constants and sequencer state type
//
// Purpose: default size limits, derived counter widths and the sequencer
// state enum, shared by the sequencer, register map and datapath.
package knn_pkg;

  localparam int MAX_VEC_LEN = 256;
  localparam int MAX_TRAIN   = 1024;
  localparam int MAX_TEST    = 1024;
  localparam int MAX_K       = 16;

  // Widths hold the inclusive maximum, not just maximum-1.
  localparam int VL_W = $clog2(MAX_VEC_LEN + 1);
  localparam int TR_W = $clog2(MAX_TRAIN + 1);
  localparam int TE_W = $clog2(MAX_TEST + 1);
  localparam int K_W  = $clog2(MAX_K + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_VOTE   = 3'd3,
    S_FINISH = 3'd4
  } knn_seq_state_t;

endpackage

// File: rtl/knn_cfg_check.sv
// rtl/knn_cfg_check.sv - combinational run-configuration validator
//
// Purpose: flags a run configuration as usable before the sequencer accepts it.
// Ports:
//   i_vec_len, i_num_train, i_num_test, i_k : candidate run configuration
//   o_cfg_ok                                : 1 when every field is in range
module knn_cfg_check #(
  parameter int MAX_VEC_LEN = knn_pkg::MAX_VEC_LEN,
  parameter int MAX_TRAIN   = knn_pkg::MAX_TRAIN,
  parameter int MAX_TEST    = knn_pkg::MAX_TEST,
  parameter int MAX_K       = knn_pkg::MAX_K,
  parameter int VL_W        = $clog2(MAX_VEC_LEN + 1),
  parameter int TR_W        = $clog2(MAX_TRAIN + 1),
  parameter int TE_W        = $clog2(MAX_TEST + 1),
  parameter int K_W         = $clog2(MAX_K + 1)
) (
  input  logic [VL_W-1:0] i_vec_len,
  input  logic [TR_W-1:0] i_num_train,
  input  logic [TE_W-1:0] i_num_test,
  input  logic [K_W-1:0]  i_k,
  output logic            o_cfg_ok
);
  import knn_pkg::*;

  // k is compared against the train count, so bring it to the train width.
  logic [TR_W-1:0] w_k_ext;
  assign w_k_ext = TR_W'(i_k);

  assign o_cfg_ok = (i_vec_len   != '0) &&
                    (i_num_train != '0) &&
                    (i_num_test  != '0) &&
                    (i_k         != '0) &&
                    (w_k_ext     <= i_num_train) &&
                    (i_k         <= K_W'(MAX_K)) &&
                    (i_vec_len   <= VL_W'(MAX_VEC_LEN)) &&
                    (i_num_train <= TR_W'(MAX_TRAIN)) &&
                    (i_num_test  <= TE_W'(MAX_TEST));

endmodule

// File: rtl/knn_sequencer.sv
// rtl/knn_sequencer.sv - k-NN run sequencer: FIFO pops and datapath strobes
//
// Purpose: on an accepted start, buffers each test vector, streams every train
// vector against it, then triggers one k-vote per test vector.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_start, i_cfg_*             : run request and configuration
//   o_busy, o_done, o_cfg_err    : run status (done/cfg_err are 1-cycle pulses)
//   i_*_empty, o_*_pop           : show-ahead test/train/label FIFO handshakes
//   i_dp_ready                   : datapath can take an element this cycle
//   o_dp_buf_wr, o_dp_elem_valid : test-buffer write / train element strobe
//   o_dp_buf_addr, o_dp_first,
//   o_dp_last, o_dp_train_idx    : element position within the current vector
//   o_dp_vote_start, i_dp_vote_done : per-test-vector vote handshake
module knn_sequencer #(
  parameter int MAX_VEC_LEN = knn_pkg::MAX_VEC_LEN,
  parameter int MAX_TRAIN   = knn_pkg::MAX_TRAIN,
  parameter int MAX_TEST    = knn_pkg::MAX_TEST,
  parameter int MAX_K       = knn_pkg::MAX_K,
  parameter int VL_W        = $clog2(MAX_VEC_LEN + 1),
  parameter int TR_W        = $clog2(MAX_TRAIN + 1),
  parameter int TE_W        = $clog2(MAX_TEST + 1),
  parameter int K_W         = $clog2(MAX_K + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [VL_W-1:0] i_cfg_vec_len,
  input  logic [TR_W-1:0] i_cfg_num_train,
  input  logic [TE_W-1:0] i_cfg_num_test,
  input  logic [K_W-1:0]  i_cfg_k,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_cfg_err,
  input  logic            i_test_empty,
  output logic            o_test_pop,
  input  logic            i_train_empty,
  output logic            o_train_pop,
  input  logic            i_label_empty,
  output logic            o_label_pop,
  input  logic            i_dp_ready,
  output logic            o_dp_buf_wr,
  output logic            o_dp_elem_valid,
  output logic [VL_W-1:0] o_dp_buf_addr,
  output logic            o_dp_first,
  output logic            o_dp_last,
  output logic [TR_W-1:0] o_dp_train_idx,
  output logic            o_dp_vote_start,
  input  logic            i_dp_vote_done
);
  import knn_pkg::*;

  knn_seq_state_t r_state, w_next;

  logic [VL_W-1:0] r_vec_len;
  logic [TR_W-1:0] r_num_train;
  logic [TE_W-1:0] r_num_test;
  logic [VL_W-1:0] r_elem;
  logic [TR_W-1:0] r_train;
  logic [TE_W-1:0] r_test;
  logic            r_cfg_err;
  logic            r_vote_issued;

  logic w_cfg_ok;
  logic w_last_elem;
  logic w_last_train;
  logic w_last_test;
  logic w_fire;

  knn_cfg_check #(
    .MAX_VEC_LEN (MAX_VEC_LEN),
    .MAX_TRAIN   (MAX_TRAIN),
    .MAX_TEST    (MAX_TEST),
    .MAX_K       (MAX_K),
    .VL_W        (VL_W),
    .TR_W        (TR_W),
    .TE_W        (TE_W),
    .K_W         (K_W)
  ) u_cfg_check (
    .i_vec_len   (i_cfg_vec_len),
    .i_num_train (i_cfg_num_train),
    .i_num_test  (i_cfg_num_test),
    .i_k         (i_cfg_k),
    .o_cfg_ok    (w_cfg_ok)
  );

  // Latched config is never zero once a run is active, so the -1 is safe.
  assign w_last_elem  = (r_elem  == r_vec_len   - VL_W'(1));
  assign w_last_train = (r_train == r_num_train - TR_W'(1));
  assign w_last_test  = (r_test  == r_num_test  - TE_W'(1));

  assign o_cfg_err = r_cfg_err;

  always_comb begin
    w_next          = r_state;
    w_fire          = 1'b0;
    o_busy          = 1'b0;
    o_done          = 1'b0;
    o_test_pop      = 1'b0;
    o_train_pop     = 1'b0;
    o_label_pop     = 1'b0;
    o_dp_buf_wr     = 1'b0;
    o_dp_elem_valid = 1'b0;
    o_dp_buf_addr   = '0;
    o_dp_first      = 1'b0;
    o_dp_last       = 1'b0;
    o_dp_train_idx  = '0;
    o_dp_vote_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_cfg_ok) w_next = S_LOAD;
      end
      S_LOAD: begin
        o_busy        = 1'b1;
        o_test_pop    = !i_test_empty;
        o_dp_buf_wr   = !i_test_empty;
        o_dp_buf_addr = r_elem;
        if (!i_test_empty && w_last_elem) w_next = S_STREAM;
      end
      S_STREAM: begin
        o_busy          = 1'b1;
        o_dp_first      = (r_elem == '0);
        o_dp_last       = w_last_elem;
        o_dp_buf_addr   = r_elem;
        o_dp_train_idx  = r_train;
        // The label is consumed with the last element, so it must be present too.
        w_fire          = !i_train_empty && i_dp_ready && (!w_last_elem || !i_label_empty);
        o_train_pop     = w_fire;
        o_dp_elem_valid = w_fire;
        o_label_pop     = w_fire && w_last_elem;
        if (w_fire && w_last_elem && w_last_train) w_next = S_VOTE;
      end
      S_VOTE: begin
        o_busy          = 1'b1;
        o_dp_vote_start = !r_vote_issued;
        if (i_dp_vote_done) w_next = w_last_test ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_vec_len     <= '0;
      r_num_train   <= '0;
      r_num_test    <= '0;
      r_elem        <= '0;
      r_train       <= '0;
      r_test        <= '0;
      r_cfg_err     <= 1'b0;
      r_vote_issued <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cfg_err     <= (r_state == S_IDLE) && i_start && !w_cfg_ok;
      // Set from the second VOTE cycle on, so the trigger is a single pulse.
      r_vote_issued <= (r_state == S_VOTE);
      case (r_state)
        S_IDLE: begin
          if (i_start && w_cfg_ok) begin
            r_vec_len   <= i_cfg_vec_len;
            r_num_train <= i_cfg_num_train;
            r_num_test  <= i_cfg_num_test;
            r_elem      <= '0;
            r_train     <= '0;
            r_test      <= '0;
          end
        end
        S_LOAD: begin
          if (!i_test_empty) begin
            if (w_last_elem) begin
              r_elem  <= '0;
              r_train <= '0;
            end else begin
              r_elem <= r_elem + VL_W'(1);
            end
          end
        end
        S_STREAM: begin
          if (w_fire) begin
            if (w_last_elem) begin
              r_elem  <= '0;
              r_train <= w_last_train ? '0 : r_train + TR_W'(1);
            end else begin
              r_elem <= r_elem + VL_W'(1);
            end
          end
        end
        S_VOTE: begin
          if (i_dp_vote_done && !w_last_test) r_test <= r_test + TE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_sequencer.sv
// tb/tb_knn_sequencer.sv - self-checking bench for knn_sequencer
module tb_knn_sequencer;
  import knn_pkg::*;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [VL_W-1:0] i_cfg_vec_len = '0;
  logic [TR_W-1:0] i_cfg_num_train = '0;
  logic [TE_W-1:0] i_cfg_num_test = '0;
  logic [K_W-1:0]  i_cfg_k = '0;
  logic            o_busy, o_done, o_cfg_err;
  logic            i_test_empty = 1'b0;
  logic            o_test_pop;
  logic            i_train_empty = 1'b0;
  logic            o_train_pop;
  logic            i_label_empty = 1'b0;
  logic            o_label_pop;
  logic            i_dp_ready = 1'b1;
  logic            o_dp_buf_wr, o_dp_elem_valid;
  logic [VL_W-1:0] o_dp_buf_addr;
  logic            o_dp_first, o_dp_last;
  logic [TR_W-1:0] o_dp_train_idx;
  logic            o_dp_vote_start;
  logic            i_dp_vote_done = 1'b0;

  always #5 clk = ~clk;

  knn_sequencer dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_cfg_vec_len   (i_cfg_vec_len),
    .i_cfg_num_train (i_cfg_num_train),
    .i_cfg_num_test  (i_cfg_num_test),
    .i_cfg_k         (i_cfg_k),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_cfg_err       (o_cfg_err),
    .i_test_empty    (i_test_empty),
    .o_test_pop      (o_test_pop),
    .i_train_empty   (i_train_empty),
    .o_train_pop     (o_train_pop),
    .i_label_empty   (i_label_empty),
    .o_label_pop     (o_label_pop),
    .i_dp_ready      (i_dp_ready),
    .o_dp_buf_wr     (o_dp_buf_wr),
    .o_dp_elem_valid (o_dp_elem_valid),
    .o_dp_buf_addr   (o_dp_buf_addr),
    .o_dp_first      (o_dp_first),
    .o_dp_last       (o_dp_last),
    .o_dp_train_idx  (o_dp_train_idx),
    .o_dp_vote_start (o_dp_vote_start),
    .i_dp_vote_done  (i_dp_vote_done)
  );

  // kind: 0 test-buffer load, 1 train element, 2 vote trigger, 3 done
  typedef struct {
    int kind;
    int addr;
    int first;
    int last;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  m_active = 1'b0;
  bit  m_err_pending = 1'b0;
  int  n_test_pops = 0;
  int  n_train_pops = 0;
  int  n_label_pops = 0;
  bit  rand_mode = 1'b0;
  bit  tb_label_empty = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit cfg_valid(input int vl, input int ntr, input int nte, input int k);
    return vl > 0 && ntr > 0 && nte > 0 && k > 0 && k <= ntr && k <= MAX_K &&
           vl <= MAX_VEC_LEN && ntr <= MAX_TRAIN && nte <= MAX_TEST;
  endfunction

  // Whole-run transaction list in the order the datapath must see it.
  task automatic build_run(input int vl, input int ntr, input int nte);
    ev_t e;
    for (int t = 0; t < nte; t++) begin
      for (int a = 0; a < vl; a++) begin
        e = '{0, a, 0, 0, 0};
        exp_q.push_back(e);
      end
      for (int tr = 0; tr < ntr; tr++) begin
        for (int a = 0; a < vl; a++) begin
          e = '{1, a, (a == 0) ? 1 : 0, (a == vl - 1) ? 1 : 0, tr};
          exp_q.push_back(e);
        end
      end
      e = '{2, 0, 0, 0, 0};
      exp_q.push_back(e);
    end
    e = '{3, 0, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  function automatic int all_outs();
    return int'({o_busy, o_done, o_cfg_err, o_test_pop, o_train_pop, o_label_pop,
                 o_dp_buf_wr, o_dp_elem_valid, o_dp_buf_addr, o_dp_first, o_dp_last,
                 o_dp_train_idx, o_dp_vote_start});
  endfunction

  // FIFO / ready environment, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      i_train_empty = 1'($urandom_range(0, 1));
      i_dp_ready    = 1'($urandom_range(0, 1));
      i_test_empty  = 1'($urandom_range(0, 1));
    end else begin
      i_train_empty = 1'b0;
      i_dp_ready    = 1'b1;
      i_test_empty  = 1'b0;
    end
    i_label_empty = tb_label_empty;
  end

  // Vote engine: done pulse 3 cycles after each trigger.
  initial begin
    forever begin
      @(negedge clk);
      if (o_dp_vote_start) begin
        repeat (3) @(posedge clk);
        #1 i_dp_vote_done = 1'b1;
        @(posedge clk);
        #1 i_dp_vote_done = 1'b0;
      end
    end
  end

  // Per-cycle compare against the expected transaction list.
  always @(negedge clk) begin
    int  nev;
    ev_t e;
    nev = int'(o_test_pop) + int'(o_dp_elem_valid) + int'(o_dp_vote_start) + int'(o_done);
    check("buf_wr_tracks_test_pop", int'(o_dp_buf_wr), int'(o_test_pop));
    check("train_pop_tracks_valid", int'(o_train_pop), int'(o_dp_elem_valid));
    check("label_pop_on_last", int'(o_label_pop), int'(o_dp_elem_valid && o_dp_last));
    if (o_test_pop) check("test_pop_while_empty", int'(i_test_empty), 0);
    if (o_train_pop) check("train_pop_blocked", int'(i_train_empty || !i_dp_ready), 0);
    if (o_label_pop) check("label_pop_while_empty", int'(i_label_empty), 0);
    if (o_done) check("busy_low_at_done", int'(o_busy), 0);
    else check("busy", int'(o_busy), int'(m_active));
    check("cfg_err", int'(o_cfg_err), int'(m_err_pending));
    m_err_pending = 1'b0;
    if (o_test_pop) n_test_pops++;
    if (o_train_pop) n_train_pops++;
    if (o_label_pop) n_label_pops++;
    if (nev != 0) begin
      check("events_per_cycle", nev, 1);
      if (exp_q.size() == 0) begin
        check("spurious_event", nev, 0);
      end else begin
        e = exp_q.pop_front();
        if (o_test_pop) begin
          check("kind_load", 0, e.kind);
          check("load_addr", int'(o_dp_buf_addr), e.addr);
        end else if (o_dp_elem_valid) begin
          check("kind_stream", 1, e.kind);
          check("stream_addr", int'(o_dp_buf_addr), e.addr);
          check("stream_first", int'(o_dp_first), e.first);
          check("stream_last", int'(o_dp_last), e.last);
          check("stream_train_idx", int'(o_dp_train_idx), e.idx);
        end else if (o_dp_vote_start) begin
          check("kind_vote", 2, e.kind);
        end else begin
          check("kind_done", 3, e.kind);
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic run_start(input int vl, input int ntr, input int nte, input int k);
    bit was_active;
    bit ok;
    was_active = m_active;
    ok = cfg_valid(vl, ntr, nte, k) && !was_active;
    if (ok) build_run(vl, ntr, nte);
    @(posedge clk);
    #1;
    i_start         = 1'b1;
    i_cfg_vec_len   = VL_W'(vl);
    i_cfg_num_train = TR_W'(ntr);
    i_cfg_num_test  = TE_W'(nte);
    i_cfg_k         = K_W'(k);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    if (ok) m_active = 1'b1;
    else if (!was_active) m_err_pending = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && m_active; i++) @(negedge clk);
    check("run_completes", int'(m_active), 0);
    if (m_active) begin
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      exp_q.delete();
      m_active = 1'b0;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_counts();
    n_test_pops = 0;
    n_train_pops = 0;
    n_label_pops = 0;
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);

    // Basic run: 2 x (4 test pops, 12 train pops, 3 label pops).
    clear_counts();
    run_start(4, 3, 2, 2);
    @(negedge clk);
    check("first_test_pop_latency", int'(o_test_pop), 1);
    wait_idle(400);
    check("basic_test_pops", n_test_pops, 8);
    check("basic_train_pops", n_train_pops, 24);
    check("basic_label_pops", n_label_pops, 6);

    // Config rejects.
    clear_counts();
    run_start(4, 4, 2, 5);
    repeat (3) @(negedge clk);
    run_start(0, 3, 1, 1);
    repeat (3) @(negedge clk);
    check("reject_pops", n_test_pops + n_train_pops + n_label_pops, 0);
    check("reject_busy", int'(o_busy), 0);

    // Random backpressure and empties.
    clear_counts();
    rand_mode = 1'b1;
    run_start(5, 4, 2, 3);
    wait_idle(3000);
    rand_mode = 1'b0;
    check("bp_train_pops", n_train_pops, 40);
    check("bp_label_pops", n_label_pops, 8);

    // Label starvation at the last element.
    tb_label_empty = 1'b1;
    run_start(4, 2, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (o_dp_last) found = 1'b1;
    end
    check("starve_reached_last", int'(found), 1);
    check("starve_addr", int'(o_dp_buf_addr), 3);
    check("starve_no_pop0", int'(o_train_pop), 0);
    @(negedge clk);
    check("starve_no_pop1", int'(o_train_pop), 0);
    @(negedge clk);
    check("starve_no_pop2", int'(o_train_pop), 0);
    tb_label_empty = 1'b0;
    @(negedge clk);
    check("starve_resume", int'(o_train_pop), 1);
    check("starve_resume_label", int'(o_label_pop), 1);
    wait_idle(200);

    // Reset mid-STREAM at train=1, elem=2.
    run_start(4, 3, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (o_train_pop && o_dp_train_idx == 1 && o_dp_buf_addr == 2) found = 1'b1;
    end
    check("rst_point_reached", int'(found), 1);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_active = 1'b0;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_midrun_outputs", all_outs(), 0);
    clear_counts();
    run_start(2, 2, 1, 1);
    wait_idle(200);
    check("post_rst_train_pops", n_train_pops, 4);

    // Start while busy is ignored.
    clear_counts();
    run_start(3, 2, 2, 1);
    repeat (5) @(negedge clk);
    run_start(5, 4, 1, 2);
    wait_idle(400);
    check("busy_start_test_pops", n_test_pops, 6);
    check("busy_start_train_pops", n_train_pops, 12);
    check("busy_start_label_pops", n_label_pops, 4);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
